word_loader: RTL and testbench

- Upstream feeder for the vocabulary matcher.
- Accepts a character byte stream over a valid/ready handshake and splits it into words.
- Writes each word, NUL-terminated, into the input buffer memory the matcher reads.
- Starts one match per word, waits for the verdict, re-arms the matcher, and reports a per-word result.

---
 rtl/matcher_pkg.sv | 23 ++
 rtl/word_loader.sv | 175 +++++++++++++++++
 tb/tb_word_loader.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matcher_pkg.sv
// Shared types and constants for the vocabulary matcher and its word loader.
package matcher_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    TERM,
    START,
    WAIT,
    REPORT,
    DRAIN
  } loader_state_t;

  typedef enum logic [1:0] {
    M_IDLE,
    M_SEARCH,
    M_DONE
  } matcher_state_t;

  localparam logic [7:0] NUL_CHAR         = 8'h00;
  localparam logic [7:0] DEFAULT_SEP_CHAR = 8'h20;

endpackage

// File: rtl/word_loader.sv
// Splits a byte stream into words, writes each one NUL-terminated into the
// matcher's input buffer, runs one match per word and reports the verdict.
module word_loader
  import matcher_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] SEP_CHAR   = DATA_WIDTH'(DEFAULT_SEP_CHAR),
  parameter int                    TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  match_cs,
  input  logic                  match_done,
  input  logic                  match_found,
  output logic                  match_clr,
  output logic                  res_valid,
  output logic                  res_found,
  output logic                  res_err,
  output logic [ADDR_WIDTH-1:0] res_len
);

  localparam int                    TW          = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_WIDTH-1:0] MAX_LEN     = '1;
  localparam logic [TW-1:0]         TIMER_LIMIT = TW'(TIMEOUT);

  loader_state_t         state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic [TW-1:0]         timer_q, timer_d, timer_inc;
  logic                  nul_pend_q, nul_pend_d;
  logic                  accept, is_sep;

  logic                  in_ready_d, mem_we_d, match_cs_d, match_clr_d;
  logic                  res_valid_d, res_found_d, res_err_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d, res_len_d;
  logic [DATA_WIDTH-1:0] mem_wdata_d;

  assign accept    = in_valid && in_ready;
  assign is_sep    = (in_data == SEP_CHAR) || (in_data == DATA_WIDTH'(NUL_CHAR));
  assign timer_inc = timer_q + TW'(1);

  // Outputs are computed for the state being entered and registered with it,
  // so every strobe is visible during the cycle its state is held.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    len_d       = len_q;
    timer_d     = timer_q;
    nul_pend_d  = nul_pend_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    match_cs_d  = 1'b0;
    match_clr_d = 1'b0;
    res_valid_d = 1'b0;
    res_found_d = 1'b0;
    res_err_d   = 1'b0;
    res_len_d   = '0;

    unique case (state_q)
      IDLE: begin
        if (accept && !is_sep) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = base_addr;
          mem_wdata_d = in_data;
          ptr_d       = base_addr + ADDR_WIDTH'(1);
          len_d       = ADDR_WIDTH'(1);
          state_d     = in_last ? TERM : LOAD;
          nul_pend_d  = in_last;
        end
      end
      LOAD: begin
        if (accept) begin
          if (is_sep) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = ptr_q;
            mem_wdata_d = DATA_WIDTH'(NUL_CHAR);
            state_d     = TERM;
          end else if (len_q == MAX_LEN) begin
            res_valid_d = 1'b1;
            res_err_d   = 1'b1;
            res_len_d   = MAX_LEN;
            state_d     = in_last ? IDLE : DRAIN;
          end else begin
            mem_we_d    = 1'b1;
            mem_addr_d  = ptr_q;
            mem_wdata_d = in_data;
            ptr_d       = ptr_q + ADDR_WIDTH'(1);
            len_d       = len_q + ADDR_WIDTH'(1);
            state_d     = in_last ? TERM : LOAD;
            nul_pend_d  = in_last;
          end
        end
      end
      DRAIN: begin
        if (accept && (is_sep || in_last)) state_d = IDLE;
      end
      TERM: begin
        // A word ended by in_last on a character still owes its NUL here.
        if (nul_pend_q) begin
          nul_pend_d  = 1'b0;
          mem_we_d    = 1'b1;
          mem_addr_d  = ptr_q;
          mem_wdata_d = DATA_WIDTH'(NUL_CHAR);
        end else begin
          match_cs_d = 1'b1;
          timer_d    = TW'(1);
          state_d    = START;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        timer_d = timer_inc;
        if (match_done || (timer_inc == TIMER_LIMIT)) begin
          res_valid_d = 1'b1;
          match_clr_d = 1'b1;
          res_found_d = match_done && match_found;
          res_err_d   = !match_done;
          res_len_d   = len_q;
          state_d     = REPORT;
        end
      end
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE) || (state_d == LOAD) || (state_d == DRAIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      len_q      <= '0;
      timer_q    <= '0;
      nul_pend_q <= 1'b0;
      in_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      match_cs   <= 1'b0;
      match_clr  <= 1'b0;
      res_valid  <= 1'b0;
      res_found  <= 1'b0;
      res_err    <= 1'b0;
      res_len    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      len_q      <= len_d;
      timer_q    <= timer_d;
      nul_pend_q <= nul_pend_d;
      in_ready   <= in_ready_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      match_cs   <= match_cs_d;
      match_clr  <= match_clr_d;
      res_valid  <= res_valid_d;
      res_found  <= res_found_d;
      res_err    <= res_err_d;
      res_len    <= res_len_d;
    end
  end

endmodule

// File: tb/tb_word_loader.sv
// Scoreboard bench for word_loader: a word-level model predicts buffer writes
// and results, a matcher model answers each start, a monitor compares.
module tb_word_loader;
  import matcher_pkg::*;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int TO = 5;
  localparam logic [7:0] SEP = 8'h20;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_last, in_ready;
  logic [DW-1:0] in_data, mem_wdata;
  logic [AW-1:0] base_addr, mem_addr, res_len;
  logic          mem_we, match_cs, match_done, match_found, match_clr;
  logic          res_valid, res_found, res_err;

  always #5 clk = ~clk;

  word_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEP_CHAR(SEP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .base_addr(base_addr), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .match_cs(match_cs), .match_done(match_done),
    .match_found(match_found), .match_clr(match_clr), .res_valid(res_valid),
    .res_found(res_found), .res_err(res_err), .res_len(res_len)
  );

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; bit nul; } wr_t;
  typedef struct { bit found; bit err; int len; bit clr; int lat; } res_t;
  typedef struct { int d; bit found; } rsp_t;

  wr_t  wq[$];
  res_t rq[$];
  rsp_t mq[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int nul_cyc  = -100;
  int cs_cyc   = -100;
  bit busy     = 0;

  // Word currently being assembled by the model and forced matcher behaviour
  byte unsigned  tok[$];
  logic [AW-1:0] tok_base;
  int            force_d = -1;
  int            force_f = -1;

  task automatic check_output(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // A word is a run of non-separator bytes closed by a separator or in_last.
  // Up to 15 characters fit; a 16th character reports an overflow instead.
  task automatic model_byte(input logic [7:0] d, input bit last, input logic [AW-1:0] base);
    bit   sep;
    rsp_t r;
    res_t e;
    sep = (d == SEP) || (d == 8'h00);
    if (!sep) begin
      if (tok.size() == 0) tok_base = base;
      if (tok.size() < 15) wq.push_back('{tok_base + AW'(tok.size()), d, 1'b0});
      else if (tok.size() == 15) rq.push_back('{1'b0, 1'b1, 15, 1'b0, -1});
      tok.push_back(d);
    end
    if (sep || last) begin
      if (tok.size() >= 1 && tok.size() <= 15) begin
        wq.push_back('{tok_base + AW'(tok.size()), 8'h00, 1'b1});
        if (force_d >= 0) r.d = force_d;
        else begin
          case ($urandom_range(0, 9))
            6, 7:    r.d = TO - 1;
            8:       r.d = 0;
            9:       r.d = TO;
            default: r.d = $urandom_range(1, 3);
          endcase
        end
        r.found = (force_f >= 0) ? bit'(force_f) : bit'($urandom_range(0, 1));
        mq.push_back(r);
        // A verdict counts only if it shows up before TIMEOUT cycles elapse
        if (r.d >= 1 && r.d < TO) e = '{r.found, 1'b0, tok.size(), 1'b1, r.d + 1};
        else                      e = '{1'b0, 1'b1, tok.size(), 1'b1, TO};
        rq.push_back(e);
      end
      tok.delete();
    end
  endtask

  // Called aligned 1 time unit after a rising edge.
  task automatic apply_stimulus(input logic [7:0] d, input bit last, input logic [AW-1:0] base);
    bit r, acc;
    acc = 0;
    in_valid = 1'b1; in_data = d; in_last = last; base_addr = base;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); r = in_ready;
      @(posedge clk); #1;
      if (r) begin acc = 1; break; end
    end
    in_valid = 1'b0; in_last = 1'b0; in_data = 8'($urandom); base_addr = AW'($urandom);
    check_output("accept_within_bound", int'(acc), 1);
    if (acc) model_byte(d, last, base);
  endtask

  task automatic send_str(input string s, input bit last, input logic [AW-1:0] base);
    for (int i = 0; i < s.len(); i++) apply_stimulus(8'(s[i]), last && (i == s.len() - 1), base);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200; i++) begin
      if (wq.size() == 0 && rq.size() == 0) break;
      idle(1);
    end
    idle(3);
    check_output("scoreboard_drained", wq.size() + rq.size(), 0);
  endtask

  task automatic check_all_zero(input string name);
    check_output(name, int'({in_ready, mem_we, mem_addr, mem_wdata, match_cs, match_clr,
                             res_valid, res_found, res_err, res_len}), 0);
  endtask

  // Matcher model: answers each start after the queued delay, holds the
  // verdict until cleared; d == 0 means it never answers.
  initial begin
    rsp_t r;
    match_done = 1'b0; match_found = 1'b0;
    forever begin
      @(negedge clk);
      if (match_cs && !rst) begin
        check_output("match_cs_expected", int'(mq.size() > 0), 1);
        if (mq.size() > 0) begin
          r = mq.pop_front();
          if (r.d > 0) begin
            repeat (r.d) @(posedge clk);
            #1 match_done = 1'b1; match_found = r.found;
            for (int i = 0; i < 20; i++) begin
              @(negedge clk);
              if (match_clr) break;
            end
            @(posedge clk);
            #1 match_done = 1'b0; match_found = 1'(($urandom_range(0, 1)));
          end
        end
      end
    end
  end

  // Monitor: compares every write, start and result against the scoreboard.
  initial begin
    wr_t  w;
    res_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) busy = 0;
      else begin
        if (mem_we) begin
          check_output("write_expected", int'(wq.size() > 0), 1);
          if (wq.size() > 0) begin
            w = wq.pop_front();
            check_output("mem_addr", int'(mem_addr), int'(w.addr));
            check_output("mem_wdata", int'(mem_wdata), int'(w.data));
            if (w.nul) begin nul_cyc = cyc; busy = 1; end
          end
        end
        if (match_cs) begin
          check_output("cs_after_nul", cyc - nul_cyc, 1);
          cs_cyc = cyc;
        end
        if (busy) check_output("in_ready_low_busy", int'(in_ready), 0);
        if (res_valid) begin
          check_output("result_expected", int'(rq.size() > 0), 1);
          if (rq.size() > 0) begin
            e = rq.pop_front();
            check_output("res_found", int'(res_found), int'(e.found));
            check_output("res_err", int'(res_err), int'(e.err));
            check_output("res_len", int'(res_len), e.len);
            check_output("match_clr", int'(match_clr), int'(e.clr));
            if (e.lat >= 0) check_output("verdict_latency", cyc - cs_cyc, e.lat);
          end
          busy = 0;
        end else if (match_clr) begin
          check_output("clr_without_result", int'(match_clr), 0);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int len;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; base_addr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset_outputs");
    @(negedge clk);
    check_output("in_ready_after_reset", int'(in_ready), 1);
    idle(1);

    $display("[TB] word 'cat '");
    force_d = 1; force_f = 1;
    send_str("cat ", 0, 4'd0);
    wait_drain();

    $display("[TB] 'ab  cd' with in_last");
    force_d = -1; force_f = -1;
    send_str("ab  cd", 1, 4'd5);
    wait_drain();

    $display("[TB] overflow then normal word");
    send_str("abcdefghijklmnopqr hi ", 0, 4'd2);
    wait_drain();

    $display("[TB] wrap at top of buffer");
    send_str("xyz ", 0, 4'd14);
    wait_drain();

    $display("[TB] timeout and late verdict");
    force_d = 0;
    send_str("to ", 0, 4'd3);
    wait_drain();
    force_d = TO - 1; force_f = 1;
    send_str("ok ", 0, 4'd9);
    wait_drain();
    force_d = TO; force_f = 1;
    send_str("late ", 0, 4'd1);
    wait_drain();

    $display("[TB] randomized stream");
    force_d = -1; force_f = -1;
    for (int t = 0; t < 40; t++) begin
      len = ($urandom_range(0, 9) < 2) ? $urandom_range(14, 18) : $urandom_range(0, 6);
      for (int i = 0; i < len; i++) begin
        logic [7:0] c;
        c = 8'($urandom_range(1, 255));
        if (c == SEP) c = 8'h41;
        apply_stimulus(c, (i == len - 1) && ($urandom_range(0, 3) == 0), AW'($urandom));
        idle($urandom_range(0, 2));
      end
      apply_stimulus($urandom_range(0, 1) ? SEP : 8'h00, bit'($urandom_range(0, 1)), AW'($urandom));
      if ($urandom_range(0, 4) == 0) apply_stimulus(SEP, 1'b0, AW'($urandom));
    end
    wait_drain();

    $display("[TB] reset while waiting for verdict");
    force_d = 0;
    send_str("dog ", 0, 4'd0);
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (match_cs) begin seen = 1; break; end
      end
      check_output("reset_test_cs_seen", int'(seen), 1);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rq.delete();
    @(negedge clk);
    check_all_zero("reset_mid_wait_outputs");
    @(posedge clk); #1;
    idle(12);
    force_d = 1; force_f = 1;
    send_str("cat ", 0, 4'd0);
    wait_drain();
    check_output("matcher_queue_empty", mq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
